// File: rtl/nic8_pkg.sv
// Shared definitions for the nic8 control path: sequencer states,
// instruction field positions, and source/destination codes.
package nic8_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int IR_SRC_MSB = 7;
  localparam int IR_SRC_LSB = 6;
  localparam int IR_DST_MSB = 5;
  localparam int IR_DST_LSB = 3;
  localparam int IR_OP_MSB  = 2;
  localparam int IR_OP_LSB  = 0;

  localparam logic [1:0] SRC_A   = 2'b00;
  localparam logic [1:0] SRC_X   = 2'b01;
  localparam logic [1:0] SRC_ALU = 2'b10;
  localparam logic [1:0] SRC_IMM = 2'b11;

  localparam logic [2:0] DST_A    = 3'b000;
  localparam logic [2:0] DST_B    = 3'b001;
  localparam logic [2:0] DST_X    = 3'b010;
  localparam logic [2:0] DST_Q    = 3'b011;
  localparam logic [2:0] DST_OUT  = 3'b100;
  localparam logic [2:0] DST_PC   = 3'b101;
  localparam logic [2:0] DST_PCZ  = 3'b110;
  localparam logic [2:0] DST_HALT = 3'b111;

  function automatic logic [1:0] ir_src(input logic [7:0] ir);
    return ir[IR_SRC_MSB:IR_SRC_LSB];
  endfunction

  function automatic logic [2:0] ir_dst(input logic [7:0] ir);
    return ir[IR_DST_MSB:IR_DST_LSB];
  endfunction

  function automatic logic [2:0] ir_op(input logic [7:0] ir);
    return ir[IR_OP_MSB:IR_OP_LSB];
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational strobe decode for the sequencer: turns (state, ir, zero)
// into destination loads, bus-source enables and PC control.
module instr_decode
  import nic8_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic [7:0] i_ir,
  input  logic       i_zero,
  output logic [4:0] o_load,
  output logic [3:0] o_assert_n,
  output logic       o_jump_take,
  output logic       o_pc_skip
);

  logic [1:0] w_src;
  logic [2:0] w_dst;

  assign w_src = ir_src(i_ir);
  assign w_dst = ir_dst(i_ir);

  // o_load order is {a, b, x, q, out}; o_assert_n order is {a, x, alu, rom}.
  always_comb begin
    o_load      = 5'b00000;
    o_assert_n  = 4'b1111;
    o_jump_take = 1'b0;
    o_pc_skip   = 1'b0;
    if ((i_state == ST_EXEC) && (w_dst != DST_HALT)) begin
      case (w_src)
        SRC_A:   o_assert_n[3] = 1'b0;
        SRC_X:   o_assert_n[2] = 1'b0;
        SRC_ALU: o_assert_n[1] = 1'b0;
        default: o_assert_n[0] = 1'b0;
      endcase
      case (w_dst)
        DST_A:   o_load[4]   = 1'b1;
        DST_B:   o_load[3]   = 1'b1;
        DST_X:   o_load[2]   = 1'b1;
        DST_Q:   o_load[1]   = 1'b1;
        DST_OUT: o_load[0]   = 1'b1;
        DST_PC:  o_jump_take = 1'b1;
        DST_PCZ: o_jump_take = i_zero;
        default: o_jump_take = 1'b0;
      endcase
      o_pc_skip = (w_src == SRC_IMM);
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// nic8 bus sequencer: two-cycle FETCH/EXEC machine owning PC, IR and halt,
// driving the data-bus source enables and destination load strobes.
module bus_sequencer
  import nic8_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [7:0] dbus,
  input  logic       zero,
  input  logic       carry,
  output logic       load_a,
  output logic       load_b,
  output logic       load_x,
  output logic       load_q,
  output logic       load_out,
  output logic       assert_a_n,
  output logic       assert_x_n,
  output logic       assert_alu_n,
  output logic       assert_rom_n,
  output logic [2:0] alu_op,
  output logic       halted
);

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;

  state_t     w_state_nxt;
  logic [7:0] w_pc_nxt;
  logic [7:0] w_ir_nxt;
  logic [4:0] w_load;
  logic [3:0] w_assert_n;
  logic       w_jump_take;
  logic       w_pc_skip;
  logic       w_unused_carry;

  assign w_unused_carry = carry;

  instr_decode u_decode (
    .i_state    (r_state),
    .i_ir       (r_ir),
    .i_zero     (zero),
    .o_load     (w_load),
    .o_assert_n (w_assert_n),
    .o_jump_take(w_jump_take),
    .o_pc_skip  (w_pc_skip)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= 8'h00;
      r_ir    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  // A taken jump replaces the operand skip; PC wraps naturally at 8 bits.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    case (r_state)
      ST_FETCH: begin
        if (run) begin
          w_ir_nxt    = rom_data;
          w_pc_nxt    = r_pc + 8'd1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_jump_take) begin
          w_pc_nxt = dbus;
        end else if (w_pc_skip) begin
          w_pc_nxt = r_pc + 8'd1;
        end
        w_state_nxt = (ir_dst(r_ir) == DST_HALT) ? ST_HALT : ST_FETCH;
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Loads are masked by reset so nothing commits on a resetting edge.
  assign load_a   = w_load[4] & ~reset;
  assign load_b   = w_load[3] & ~reset;
  assign load_x   = w_load[2] & ~reset;
  assign load_q   = w_load[1] & ~reset;
  assign load_out = w_load[0] & ~reset;

  assign assert_a_n   = w_assert_n[3];
  assign assert_x_n   = w_assert_n[2];
  assign assert_alu_n = w_assert_n[1];
  assign assert_rom_n = w_assert_n[0];

  assign rom_addr = r_pc;
  assign alu_op   = ir_op(r_ir);
  assign halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed scenarios plus a random
// program walked against an instruction-level reference model.
module tb_bus_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] dbus;
  logic       zero;
  logic       carry;
  logic       load_a, load_b, load_x, load_q, load_out;
  logic       assert_a_n, assert_x_n, assert_alu_n, assert_rom_n;
  logic [2:0] alu_op;
  logic       halted;

  logic [7:0] rom [256];
  int         nCompared;
  int         nMismatched;

  localparam logic [8:0] IDLE = 9'b00000_1111;

  logic [8:0] strobes;
  assign strobes = {load_a, load_b, load_x, load_q, load_out,
                    assert_a_n, assert_x_n, assert_alu_n, assert_rom_n};
  assign rom_data = rom[rom_addr];

  bus_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .dbus        (dbus),
    .zero        (zero),
    .carry       (carry),
    .load_a      (load_a),
    .load_b      (load_b),
    .load_x      (load_x),
    .load_q      (load_q),
    .load_out    (load_out),
    .assert_a_n  (assert_a_n),
    .assert_x_n  (assert_x_n),
    .assert_alu_n(assert_alu_n),
    .assert_rom_n(assert_rom_n),
    .alu_op      (alu_op),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    run   = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    run = 1'b0; zero = 1'b0; dbus = 8'h00; reset = 1'b1;
    tick();
    tick();
    nCompared++;
    if (strobes !== IDLE) begin
      nMismatched++;
      $display("[TB] FAIL reset_strobes: got %b expected %b", strobes, IDLE);
    end
    reset = 1'b0;
    #1;
    nCompared++;
    if (rom_addr !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL reset_addr: got %h expected 00", rom_addr);
    end
    nCompared++;
    if ({halted, alu_op} !== 4'b0000) begin
      nMismatched++;
      $display("[TB] FAIL reset_halt_op: got %b expected 0000", {halted, alu_op});
    end
  endtask

  task automatic test_imm_load();
    clear_rom(); rom[0] = 8'hC0; rom[1] = 8'h5A;
    do_reset();
    run = 1'b1;
    tick();
    nCompared++;
    if ({rom_addr, strobes} !== {8'h01, 9'b10000_1110}) begin
      nMismatched++;
      $display("[TB] FAIL imm_exec: got %h/%b expected 01/100001110", rom_addr, strobes);
    end
    tick();
    nCompared++;
    if ({rom_addr, strobes} !== {8'h02, IDLE}) begin
      nMismatched++;
      $display("[TB] FAIL imm_next: got %h/%b expected 02/%b", rom_addr, strobes, IDLE);
    end
  endtask

  task automatic test_jump();
    clear_rom(); rom[0] = 8'hE8; rom[1] = 8'h10;
    do_reset();
    dbus = 8'h10; run = 1'b1;
    tick();
    nCompared++;
    if (strobes !== 9'b00000_1110) begin
      nMismatched++;
      $display("[TB] FAIL jump_exec: got %b expected 000001110", strobes);
    end
    tick();
    nCompared++;
    if (rom_addr !== 8'h10) begin
      nMismatched++;
      $display("[TB] FAIL jump_target: got %h expected 10", rom_addr);
    end
  endtask

  task automatic test_cond_jump();
    for (int z = 0; z < 2; z++) begin
      clear_rom(); rom[0] = 8'hF0;
      do_reset();
      dbus = 8'h40; zero = (z == 1); run = 1'b1;
      tick();
      nCompared++;
      if (strobes !== 9'b00000_1110) begin
        nMismatched++;
        $display("[TB] FAIL jz_exec z=%0d: got %b expected 000001110", z, strobes);
      end
      tick();
      nCompared++;
      if (rom_addr !== ((z == 1) ? 8'h40 : 8'h02)) begin
        nMismatched++;
        $display("[TB] FAIL jz_target z=%0d: got %h expected %h", z, rom_addr,
                 (z == 1) ? 8'h40 : 8'h02);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_alu_out();
    clear_rom(); rom[0] = 8'hA3;
    do_reset();
    run = 1'b1;
    tick();
    nCompared++;
    if ({alu_op, strobes} !== {3'd3, 9'b00001_1101}) begin
      nMismatched++;
      $display("[TB] FAIL alu_exec: got %0d/%b expected 3/000011101", alu_op, strobes);
    end
    tick();
    nCompared++;
    if (rom_addr !== 8'h01) begin
      nMismatched++;
      $display("[TB] FAIL alu_next: got %h expected 01", rom_addr);
    end
  endtask

  task automatic test_halt();
    int bad;
    clear_rom(); rom[0] = 8'h38;
    do_reset();
    run = 1'b1;
    tick();
    nCompared++;
    if (strobes !== IDLE) begin
      nMismatched++;
      $display("[TB] FAIL halt_exec: got %b expected %b", strobes, IDLE);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({halted, rom_addr, strobes} !== {1'b1, 8'h01, IDLE}) bad++;
    end
    nCompared++;
    if (bad != 0) begin
      nMismatched++;
      $display("[TB] FAIL halt_hold: got %0d bad cycles, last %b/%h/%b expected 0 bad",
               bad, halted, rom_addr, strobes);
    end
    do_reset();
    nCompared++;
    if ({halted, rom_addr} !== {1'b0, 8'h00}) begin
      nMismatched++;
      $display("[TB] FAIL halt_reset: got %b/%h expected 0/00", halted, rom_addr);
    end
  endtask

  task automatic test_pc_wrap();
    clear_rom(); rom[0] = 8'h28; rom[8'hFF] = 8'hC0; rom[0] = 8'h28;
    do_reset();
    dbus = 8'hFF; run = 1'b1;
    tick();
    tick();
    nCompared++;
    if (rom_addr !== 8'hFF) begin
      nMismatched++;
      $display("[TB] FAIL wrap_setup: got %h expected ff", rom_addr);
    end
    tick();
    nCompared++;
    if (rom_addr !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL wrap_operand: got %h expected 00", rom_addr);
    end
    tick();
    nCompared++;
    if (rom_addr !== 8'h01) begin
      nMismatched++;
      $display("[TB] FAIL wrap_next: got %h expected 01", rom_addr);
    end
  endtask

  task automatic test_run_hold();
    int bad;
    clear_rom(); rom[0] = 8'hC0;
    do_reset();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({rom_addr, strobes} !== {8'h00, IDLE}) bad++;
    end
    nCompared++;
    if (bad != 0) begin
      nMismatched++;
      $display("[TB] FAIL run_hold: got %0d bad cycles expected 0", bad);
    end
    run = 1'b1;
    tick();
    nCompared++;
    if (rom_addr !== 8'h01) begin
      nMismatched++;
      $display("[TB] FAIL run_resume: got %h expected 01", rom_addr);
    end
  endtask

  task automatic test_reset_mid_exec();
    clear_rom(); rom[0] = 8'hC8; rom[1] = 8'h77;
    do_reset();
    run = 1'b1;
    tick();
    nCompared++;
    if (load_b !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL midreset_pre: got load_b=%b expected 1", load_b);
    end
    reset = 1'b1;
    #1;
    nCompared++;
    if (load_b !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_gate: got load_b=%b expected 0", load_b);
    end
    tick();
    reset = 1'b0; run = 1'b0;
    #1;
    nCompared++;
    if ({rom_addr, strobes} !== {8'h00, IDLE}) begin
      nMismatched++;
      $display("[TB] FAIL midreset_after: got %h/%b expected 00/%b", rom_addr, strobes, IDLE);
    end
  endtask

  // Instruction-level model: each instruction is one fetch then one exec.
  task automatic test_random();
    logic [7:0] pc, ir, expAddr;
    logic [1:0] src;
    logic [2:0] dst;
    logic [4:0] expLoad;
    logic [3:0] expAssert;
    int stall;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom_range(0, 255));
      if (rom[i][5:3] == 3'b111) rom[i][5:3] = 3'b000;
    end
    do_reset();
    pc = 8'h00;
    for (int n = 0; n < 80; n++) begin
      stall = $urandom_range(0, 2);
      run = 1'b0;
      for (int s = 0; s < stall; s++) tick();
      nCompared++;
      if ({rom_addr, strobes} !== {pc, IDLE}) begin
        nMismatched++;
        $display("[TB] FAIL rnd_fetch n=%0d: got %h/%b expected %h/%b", n, rom_addr, strobes, pc, IDLE);
      end
      ir = rom[pc];
      src = ir[7:6];
      dst = ir[5:3];
      zero = 1'($urandom_range(0, 1));
      dbus = 8'($urandom_range(0, 255));
      run = 1'b1;
      tick();
      run = 1'($urandom_range(0, 1));
      #1;
      expLoad   = (dst < 3'd5) ? (5'b10000 >> dst) : 5'b00000;
      expAssert = ~(4'b1000 >> src);
      expAddr   = pc + 8'd1;
      nCompared++;
      if ({rom_addr, alu_op, strobes} !== {expAddr, ir[2:0], expLoad, expAssert}) begin
        nMismatched++;
        $display("[TB] FAIL rnd_exec n=%0d ir=%h: got %h/%0d/%b expected %h/%0d/%b", n, ir,
                 rom_addr, alu_op, strobes, expAddr, ir[2:0], {expLoad, expAssert});
      end
      if (dst == 3'd5 || (dst == 3'd6 && zero)) pc = dbus;
      else pc = pc + 8'd1 + ((src == 2'd3) ? 8'd1 : 8'd0);
      tick();
    end
    run = 1'b0;
    #1;
    nCompared++;
    if (rom_addr !== pc) begin
      nMismatched++;
      $display("[TB] FAIL rnd_final: got %h expected %h", rom_addr, pc);
    end
  endtask

  initial begin
    nCompared = 0; nMismatched = 0;
    reset = 1'b1; run = 1'b0; dbus = 8'h00; zero = 1'b0; carry = 1'b0;
    clear_rom();
    test_reset();
    test_imm_load();
    test_jump();
    test_cond_jump();
    test_alu_out();
    test_halt();
    test_pc_wrap();
    test_run_hold();
    test_reset_mid_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
